gpio_ctrl: RTL

GPIO controller sitting directly upstream of the chip pad wrapper. It owns the pin data register and tristate register that drive the pads, and synchronizes the returned pin state. It detects rising and falling edges and raises a level interrupt. Its register file is memory-mapped and reached from the core's peripheral bus through a simple one-cycle read/write port.

---
 rtl/gpio_pkg.sv | 22 ++
 rtl/gpio_sync_edge.sv | 52 +++++
 rtl/gpio_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the GPIO controller.
// Holds the register address map, synchronizer depth and warm-up length.
package gpio_pkg;

  localparam int unsigned ADDR_W        = 4;
  localparam int unsigned SYNC_STAGES   = 2;
  localparam int unsigned WARMUP_CYCLES = 3;
  localparam int unsigned WARMUP_W      = 2;

  // Word register addresses
  localparam logic [ADDR_W-1:0] GPIO_DR      = 4'd0;
  localparam logic [ADDR_W-1:0] GPIO_TS      = 4'd1;
  localparam logic [ADDR_W-1:0] GPIO_PS      = 4'd2;
  localparam logic [ADDR_W-1:0] GPIO_DR_SET  = 4'd3;
  localparam logic [ADDR_W-1:0] GPIO_DR_CLR  = 4'd4;
  localparam logic [ADDR_W-1:0] GPIO_DR_TGL  = 4'd5;
  localparam logic [ADDR_W-1:0] GPIO_RISE_EN = 4'd6;
  localparam logic [ADDR_W-1:0] GPIO_FALL_EN = 4'd7;
  localparam logic [ADDR_W-1:0] GPIO_IE      = 4'd8;
  localparam logic [ADDR_W-1:0] GPIO_IP      = 4'd9;

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: synchronizes asynchronous pin state and detects edges.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_pin               raw asynchronous pin state
//   i_rise_en/i_fall_en per-pin edge enables
//   o_ps_sync           synchronized pin state (last synchronizer stage)
//   o_rise_evt_c        per-pin rising-edge event (combinational)
//   o_fall_evt_c        per-pin falling-edge event (combinational)
module gpio_sync_edge
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_pin,
  input  logic [WIDTH-1:0] i_rise_en,
  input  logic [WIDTH-1:0] i_fall_en,
  output logic [WIDTH-1:0] o_ps_sync,
  output logic [WIDTH-1:0] o_rise_evt_c,
  output logic [WIDTH-1:0] o_fall_evt_c
);

  logic [WIDTH-1:0]    r_sync [SYNC_STAGES];
  logic [WIDTH-1:0]    r_prev;
  logic [WARMUP_W-1:0] r_warm;
  logic                w_armed;
  logic [WIDTH-1:0]    w_s2;

  // Edge detection stays off until the synchronizer has flushed its reset zeros
  assign w_armed = (r_warm == WARMUP_W'(WARMUP_CYCLES));
  assign w_s2    = r_sync[SYNC_STAGES-1];

  // Synchronizer chain, edge-compare flop and warm-up counter
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
      r_warm <= '0;
    end else begin
      r_sync[0] <= i_pin;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_s2;
      if (!w_armed) r_warm <= r_warm + WARMUP_W'(1);
    end
  end

  assign o_ps_sync    = w_s2;
  assign o_rise_evt_c = {WIDTH{w_armed}} &  w_s2 & ~r_prev & i_rise_en;
  assign o_fall_evt_c = {WIDTH{w_armed}} & ~w_s2 &  r_prev & i_fall_en;

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO controller upstream of the pad wrapper.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   addr             word register select
//   wr_en, wdata     single-cycle write strobe and data
//   rd_en            single-cycle read strobe
//   rdata, rvalid    registered read data and its one-cycle qualifier
//   gpio_dr, gpio_ts pin data and output enable to the pads (1 = drive)
//   gpio_ps          raw asynchronous pin state from the pads
//   irq              level interrupt, |(IP & IE)
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid,
  output logic [WIDTH-1:0]  gpio_dr,
  output logic [WIDTH-1:0]  gpio_ts,
  input  logic [WIDTH-1:0]  gpio_ps,
  output logic              irq
);

  logic [WIDTH-1:0] r_dr, r_ts, r_rise_en, r_fall_en, r_ie, r_ip, r_rdata;
  logic             r_rvalid, r_irq;

  logic [WIDTH-1:0] w_ps_sync, w_rise_evt, w_fall_evt;
  logic [WIDTH-1:0] w_dr_next, w_ts_next, w_rise_en_next, w_fall_en_next;
  logic [WIDTH-1:0] w_ie_next, w_ip_next, w_ip_clr, w_rd_data;

  gpio_sync_edge #(.WIDTH(WIDTH)) u_sync_edge (
    .clk          (clk),
    .reset        (reset),
    .i_pin        (gpio_ps),
    .i_rise_en    (r_rise_en),
    .i_fall_en    (r_fall_en),
    .o_ps_sync    (w_ps_sync),
    .o_rise_evt_c (w_rise_evt),
    .o_fall_evt_c (w_fall_evt)
  );

  // Register write decode; a new edge wins over a W1C clear of the same bit
  always_comb begin
    w_dr_next      = r_dr;
    w_ts_next      = r_ts;
    w_rise_en_next = r_rise_en;
    w_fall_en_next = r_fall_en;
    w_ie_next      = r_ie;
    w_ip_clr       = '0;
    if (wr_en) begin
      case (addr)
        GPIO_DR:      w_dr_next      = wdata;
        GPIO_TS:      w_ts_next      = wdata;
        GPIO_DR_SET:  w_dr_next      = r_dr | wdata;
        GPIO_DR_CLR:  w_dr_next      = r_dr & ~wdata;
        GPIO_DR_TGL:  w_dr_next      = r_dr ^ wdata;
        GPIO_RISE_EN: w_rise_en_next = wdata;
        GPIO_FALL_EN: w_fall_en_next = wdata;
        GPIO_IE:      w_ie_next      = wdata;
        GPIO_IP:      w_ip_clr       = wdata;
        default: ;
      endcase
    end
    w_ip_next = (r_ip & ~w_ip_clr) | w_rise_evt | w_fall_evt;
  end

  // Read mux over pre-write register values; write-only and unmapped read 0
  always_comb begin
    w_rd_data = '0;
    case (addr)
      GPIO_DR:      w_rd_data = r_dr;
      GPIO_TS:      w_rd_data = r_ts;
      GPIO_PS:      w_rd_data = w_ps_sync;
      GPIO_RISE_EN: w_rd_data = r_rise_en;
      GPIO_FALL_EN: w_rd_data = r_fall_en;
      GPIO_IE:      w_rd_data = r_ie;
      GPIO_IP:      w_rd_data = r_ip;
      default: ;
    endcase
  end

  // Register file, read port and interrupt output
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dr      <= '0;
      r_ts      <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_ie      <= '0;
      r_ip      <= '0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_dr      <= w_dr_next;
      r_ts      <= w_ts_next;
      r_rise_en <= w_rise_en_next;
      r_fall_en <= w_fall_en_next;
      r_ie      <= w_ie_next;
      r_ip      <= w_ip_next;
      if (rd_en) r_rdata <= w_rd_data;
      r_rvalid  <= rd_en;
      // Computed from next-state so irq tracks IP & IE in the same cycle
      r_irq     <= |(w_ip_next & w_ie_next);
    end
  end

  assign rdata   = r_rdata;
  assign rvalid  = r_rvalid;
  assign gpio_dr = r_dr;
  assign gpio_ts = r_ts;
  assign irq     = r_irq;

endmodule
